iir_biquad_output_stage: RTL and testbench

// - Downstream of the biquad core. Captures each filtered sample on y0_valid/y0,

---
 rtl/iir_biquad_output_stage.sv | 172 +++++++++++++++++
 tb/tb_iir_biquad_output_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/iir_biquad_output_stage.sv
// iir_biquad_output_stage
// Captures filtered samples from the biquad core, applies a signed Q-format
// output gain with saturation, and buffers results in a small first-word
// fall-through FIFO presented as a valid/ready stream. The core cannot be
// stalled, so a full FIFO drops the incoming sample and raises a sticky flag.
module iir_biquad_output_stage #(
    parameter int N_BITS_P     = 32,
    parameter int Q_BITS_P     = 11,
    parameter int FIFO_DEPTH_P = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            y0_valid,
    input  logic [N_BITS_P-1:0]             y0,
    input  logic [N_BITS_P-1:0]             cr_gain,
    input  logic                            cr_clear,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [N_BITS_P-1:0]             m_data,
    output logic [$clog2(FIFO_DEPTH_P):0]   sr_fill,
    output logic                            sr_clip,
    output logic                            sr_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH_P);
    localparam int FW = AW + 1;
    localparam int PW = 2 * N_BITS_P;

    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-N_BITS_P+1){1'b0}}, {(N_BITS_P-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-N_BITS_P+1){1'b1}}, {(N_BITS_P-1){1'b0}}};
    localparam logic [FW-1:0]        FILL_FULL = FW'(FIFO_DEPTH_P);
    localparam logic [FW-1:0]        FILL_ONE  = FW'(1);
    localparam logic [AW-1:0]        PTR_ONE   = AW'(1);

    // Floor-scale a full-width product by the fractional bits and clamp it to
    // the output range. Returns {clipped, result}.
    function automatic logic [N_BITS_P:0] saturate(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] sc;
        sc = p >>> Q_BITS_P;
        if (sc > SAT_MAX) begin
            saturate = {1'b1, SAT_MAX[N_BITS_P-1:0]};
        end else if (sc < SAT_MIN) begin
            saturate = {1'b1, SAT_MIN[N_BITS_P-1:0]};
        end else begin
            saturate = {1'b0, sc[N_BITS_P-1:0]};
        end
    endfunction

    logic                       s1_valid_r;
    logic signed [PW-1:0]       prod_r;
    logic [N_BITS_P-1:0]        mem_r [FIFO_DEPTH_P];
    logic [AW-1:0]              wr_ptr_r;
    logic [AW-1:0]              rd_ptr_r;
    logic [FW-1:0]              fill_r;
    logic                       m_valid_r;
    logic [N_BITS_P-1:0]        m_data_r;
    logic                       clip_r;
    logic                       ovf_r;

    logic [N_BITS_P:0]          sat_s;
    logic                       pop_s;
    logic                       full_s;
    logic                       push_s;
    logic                       drop_s;
    logic                       clip_evt_s;
    logic [AW-1:0]              rd_next_s;
    logic [FW-1:0]              fill_next_s;
    logic [N_BITS_P-1:0]        head_next_s;

    // Stage 1: sign-extended full-width product, sampled with the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            prod_r     <= '0;
        end else begin
            s1_valid_r <= y0_valid;
            if (y0_valid) begin
                prod_r <= $signed({{N_BITS_P{y0[N_BITS_P-1]}}, y0}) *
                          $signed({{N_BITS_P{cr_gain[N_BITS_P-1]}}, cr_gain});
            end else begin
                prod_r <= prod_r;
            end
        end
    end

    // Stage 2 and FIFO control: saturation, push/pop decisions and the next head word.
    always_comb begin
        sat_s       = saturate(prod_r);
        pop_s       = m_valid_r && m_ready;
        full_s      = (fill_r == FILL_FULL);
        push_s      = s1_valid_r && (!full_s || pop_s);
        drop_s      = s1_valid_r && full_s && !pop_s;
        clip_evt_s  = s1_valid_r && sat_s[N_BITS_P];
        rd_next_s   = rd_ptr_r;
        fill_next_s = fill_r;
        head_next_s = m_data_r;
        if (pop_s) begin
            rd_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_next_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   fill_next_s = fill_r + FILL_ONE;
            2'b01:   fill_next_s = fill_r - FILL_ONE;
            default: fill_next_s = fill_r;
        endcase
        // The head can only be the word being written when the FIFO is (or is
        // becoming) empty apart from it; otherwise it already sits in memory.
        if (fill_next_s == '0) begin
            head_next_s = m_data_r;
        end else if (push_s && (wr_ptr_r == rd_next_s)) begin
            head_next_s = sat_s[N_BITS_P-1:0];
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // FIFO storage, pointers, occupancy and registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH_P; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            fill_r    <= '0;
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= sat_s[N_BITS_P-1:0];
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r        <= wr_ptr_r;
            end
            rd_ptr_r  <= rd_next_s;
            fill_r    <= fill_next_s;
            m_valid_r <= (fill_next_s != '0);
            m_data_r  <= head_next_s;
        end
    end

    // Sticky status flags; a new event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            if (clip_evt_s) begin
                clip_r <= 1'b1;
            end else if (cr_clear) begin
                clip_r <= 1'b0;
            end else begin
                clip_r <= clip_r;
            end
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (cr_clear) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    assign m_valid     = m_valid_r;
    assign m_data      = m_data_r;
    assign sr_fill     = fill_r;
    assign sr_clip     = clip_r;
    assign sr_overflow = ovf_r;

endmodule

// File: tb/tb_iir_biquad_output_stage.sv
// Directed bench for iir_biquad_output_stage with hand-computed expectations.
module tb_iir_biquad_output_stage;

    logic        clk;
    logic        rst_n;
    logic        y0_valid;
    logic [31:0] y0;
    logic [31:0] cr_gain;
    logic        cr_clear;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [2:0]  sr_fill;
    logic        sr_clip;
    logic        sr_overflow;

    int n_chk  = 0;
    int n_fail = 0;

    iir_biquad_output_stage #(
        .N_BITS_P     (32),
        .Q_BITS_P     (11),
        .FIFO_DEPTH_P (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .y0_valid    (y0_valid),
        .y0          (y0),
        .cr_gain     (cr_gain),
        .cr_clear    (cr_clear),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .sr_fill     (sr_fill),
        .sr_clip     (sr_clip),
        .sr_overflow (sr_overflow)
    );

    // Free-running clock, 10 time units period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [31:0] v);
        y0       = v;
        y0_valid = 1'b1;
        step();
        y0_valid = 1'b0;
    endtask

    // Directed stimulus sequence.
    initial begin
        rst_n    = 1'b0;
        y0_valid = 1'b0;
        y0       = 32'd0;
        cr_gain  = 32'd2048;
        cr_clear = 1'b0;
        m_ready  = 1'b1;
        step();
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_fill", {29'd0, sr_fill}, 32'd0);
        chk("rst_clip", {31'd0, sr_clip}, 32'd0);
        chk("rst_ovf", {31'd0, sr_overflow}, 32'd0);
        rst_n = 1'b1;
        step();

        // Unity gain: visible two edges after the strobe, popped on the next.
        strobe(32'd1000);
        chk("unity_not_yet", {31'd0, m_valid}, 32'd0);
        step();
        chk("unity_valid", {31'd0, m_valid}, 32'd1);
        chk("unity_data", m_data, 32'd1000);
        chk("unity_fill1", {29'd0, sr_fill}, 32'd1);
        step();
        chk("unity_fill0", {29'd0, sr_fill}, 32'd0);
        chk("unity_drained", {31'd0, m_valid}, 32'd0);
        chk("unity_hold", m_data, 32'd1000);

        // Gain sampled with the strobe: later gain change must not affect it.
        strobe(32'd100);
        cr_gain = 32'd8192;
        step();
        chk("gain_sampled", m_data, 32'd100);
        step();

        // Fractional gain 2.5 on a negative sample: -400 -> -1000.
        cr_gain = 32'd5120;
        strobe(32'hFFFF_FE70);
        step();
        chk("frac_neg", m_data, 32'hFFFF_FC18);
        step();
        // Gain 0.5 on -1 floors to -1.
        cr_gain = 32'd1024;
        strobe(32'hFFFF_FFFF);
        step();
        chk("frac_floor", m_data, 32'hFFFF_FFFF);
        chk("no_clip_yet", {31'd0, sr_clip}, 32'd0);
        step();

        // Saturation at both ends with gain 2.0.
        cr_gain = 32'd4096;
        strobe(32'h7FFF_0000);
        step();
        chk("sat_pos", m_data, 32'h7FFF_FFFF);
        chk("sat_pos_clip", {31'd0, sr_clip}, 32'd1);
        step();
        strobe(32'h8001_0000);
        step();
        chk("sat_neg", m_data, 32'h8000_0000);
        chk("sat_neg_clip", {31'd0, sr_clip}, 32'd1);
        step();
        cr_clear = 1'b1;
        step();
        cr_clear = 1'b0;
        chk("clip_cleared", {31'd0, sr_clip}, 32'd0);

        // Overflow: five back-to-back strobes into a stalled FIFO.
        cr_gain = 32'd2048;
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            strobe(32'(i));
        end
        step();
        chk("ovf_fill", {29'd0, sr_fill}, 32'd4);
        chk("ovf_flag", {31'd0, sr_overflow}, 32'd1);
        chk("ovf_stable", m_data, 32'd1);
        step();
        chk("ovf_stall_hold", m_data, 32'd1);
        m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_drain", m_data, 32'(i));
            step();
        end
        chk("ovf_empty", {31'd0, m_valid}, 32'd0);
        chk("ovf_last_hold", m_data, 32'd4);
        cr_clear = 1'b1;
        step();
        cr_clear = 1'b0;
        chk("ovf_cleared", {31'd0, sr_overflow}, 32'd0);

        // Full FIFO with push and pop on the same edge: no overflow.
        m_ready = 1'b0;
        for (int i = 5; i <= 8; i++) begin
            strobe(32'(i));
        end
        step();
        chk("full_fill", {29'd0, sr_fill}, 32'd4);
        strobe(32'd9);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("pp_fill", {29'd0, sr_fill}, 32'd4);
        chk("pp_no_ovf", {31'd0, sr_overflow}, 32'd0);
        chk("pp_head", m_data, 32'd6);
        m_ready = 1'b1;
        for (int i = 6; i <= 9; i++) begin
            chk("pp_drain", m_data, 32'(i));
            step();
        end
        chk("pp_empty", {29'd0, sr_fill}, 32'd0);

        // Clear on the same edge as an overflow event: the event wins.
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            strobe(32'(i));
        end
        step();
        strobe(32'd10);
        cr_clear = 1'b1;
        step();
        cr_clear = 1'b0;
        chk("clr_vs_ovf", {31'd0, sr_overflow}, 32'd1);
        chk("clr_vs_ovf_fill", {29'd0, sr_fill}, 32'd4);

        // Reset mid-operation: 3 entries buffered and a sample in stage 1.
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("mid_fill3", {29'd0, sr_fill}, 32'd3);
        strobe(32'd11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, m_valid}, 32'd0);
        chk("mid_rst_data", m_data, 32'd0);
        chk("mid_rst_fill", {29'd0, sr_fill}, 32'd0);
        chk("mid_rst_ovf", {31'd0, sr_overflow}, 32'd0);
        chk("mid_rst_clip", {31'd0, sr_clip}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_fill", {29'd0, sr_fill}, 32'd0);
        strobe(32'd7);
        step();
        chk("post_rst_one", {29'd0, sr_fill}, 32'd1);
        chk("post_rst_data", m_data, 32'd7);
        chk("post_rst_valid", {31'd0, m_valid}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
